writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port wb_valid  input  1  write-back bundle present this cycle.
REQ-004 SHALL have port wb_bundle  input  20  [15:0] data, [18:16] destination register, [19] is_write.
REQ-005 SHALL have port wb_ready  output  1  unit accepts a bundle this cycle.
REQ-006 SHALL have port hold  input  1  when high, the unit stops draining its queue into the register file.
REQ-007 SHALL have port rd_addr_a  input  3  read port A register index.
REQ-008 SHALL have port rd_data_a  output  16  read port A data, combinational.
REQ-009 SHALL have port rd_addr_b  input  3  read port B register index.
REQ-010 SHALL have port rd_data_b  output  16  read port B data, combinational.
REQ-011 SHALL have port commit_valid  output  1  registered pulse: a register write completed on the previous edge.
REQ-012 SHALL have port commit_reg  output  3  register index of the completed write.
REQ-013 SHALL have port commit_data  output  16  data of the completed write.
REQ-014 SHALL have port retired_count  output  16  count of bundles drained, including non-writing bundles.
REQ-015 SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, at least 2).

Function
REQ-016 SHALL contain 8 x 16-bit registers R0..R7; R0 always reads 0, and writes to R0 are dropped but still retire.
REQ-017 SHALL accept a bundle on an edge when wb_valid and wb_ready are both high, pushing it into a FIFO of DEPTH entries.
REQ-018 SHALL drive wb_ready = (count < DEPTH) and not rst; wb_ready SHALL NOT depend on same-cycle pop.
REQ-019 SHALL pop the FIFO head on each edge where count > 0 and hold is low.
REQ-020 On pop, SHALL write head data to the register file iff head is_write = 1 and head reg != 0.
REQ-021 SHALL apply push and pop on the same edge as count unchanged, with correct FIFO ordering.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL give a bundle accepted on edge N, with an empty queue and hold low, a register-file update on edge N+1; commit_valid SHALL be high during the cycle after edge N+1.
REQ-024 SHALL, on each pop, register commit_valid = head is_write and (reg != 0), commit_reg = head reg, and commit_data = head data; commit_valid SHALL be 0 in other cycles, and commit_reg/commit_data SHALL hold their last values.
REQ-025 SHALL increment retired_count by 1 per pop, wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL resolve each read port with priority: index 0 yields 0; else the youngest queued entry with is_write=1 and matching reg; else the register file.
REQ-027 SHALL exclude an entry pushed on the current edge from bypass until it is resident, i.e. wb_bundle itself is never bypassed.
REQ-028 SHALL make hold affect only draining; pushes SHALL continue until the queue is full.
REQ-029 SHALL ignore wb_bundle contents when wb_valid is low or wb_ready is low (no push, no state change).

Reset
REQ-030 While rst is high, SHALL clear all registers R0..R7 to 0, empty the FIFO (count=0, pointers=0), and drive commit_valid=0, commit_reg=0, commit_data=0, retired_count=0, wb_ready=0.
REQ-031 SHALL drop queued entries without committing them if rst asserts mid-operation.
REQ-032 SHALL drive wb_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 Bench SHALL cover basic write: push {1,R3,0x1234}, hold=0 -> edge+1 R3=0x1234; commit_valid pulse with reg 3 and data 0x1234; retired_count=1.
REQ-034 Bench SHALL cover full and bypass: hold=1, push {1,R2,0xAAAA} then {1,R2,0xBBBB} -> wb_ready=0 and rd_addr_a=2 reads 0xBBBB; release hold -> R2=0xBBBB after two pops.
REQ-035 Bench SHALL cover R0 and no-write bundles: push {1,R0,0xFFFF} then {0,R5,0x0042} -> R0 reads 0, R5 unchanged, commit_valid never high, retired_count=2.
REQ-036 Bench SHALL cover simultaneous push and pop: stream back-to-back bundles to R1..R7 with hold=0 -> count stays at or below 1, wb_ready stays high, and every register matches in order.
REQ-037 Bench SHALL cover reset mid-operation: fill queue with hold=1, pulse rst asynchronously -> all registers 0, queue empty, retired_count=0, and no commit pulse after reset.
REQ-038 Bench SHALL cover counter wrap: preload 0xFFFF pops, then pop once more -> retired_count=0x0000.

Source files
------------

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - write-back queue draining into an 8x16 register file
// Bundles queue in a DEPTH-entry FIFO; read ports bypass from the youngest queued write.
module writeback_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [19:0] wb_bundle,
   output logic        wb_ready,
   input  logic        hold,
   input  logic [2:0]  rd_addr_a,
   output logic [15:0] rd_data_a,
   input  logic [2:0]  rd_addr_b,
   output logic [15:0] rd_data_b,
   output logic        commit_valid,
   output logic [2:0]  commit_reg,
   output logic [15:0] commit_data,
   output logic [15:0] retired_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic        is_write;
      logic [2:0]  rd;
      logic [15:0] data;
   } entry_t;

   logic [15:0]      regs_q [8];
   logic [15:0]      regs_d [8];
   entry_t           fifo_q [DEPTH];
   entry_t           fifo_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             commit_valid_q, commit_valid_d;
   logic [2:0]       commit_reg_q, commit_reg_d;
   logic [15:0]      commit_data_q, commit_data_d;
   logic [15:0]      retired_q, retired_d;

   logic   push;
   logic   pop;
   entry_t head;

   assign wb_ready      = (count_q < DEPTH_C) && !rst;
   assign push          = wb_valid && wb_ready;
   assign pop           = (count_q != '0) && !hold;
   assign head          = fifo_q[rd_ptr_q];
   assign commit_valid  = commit_valid_q;
   assign commit_reg    = commit_reg_q;
   assign commit_data   = commit_data_q;
   assign retired_count = retired_q;

   always_comb begin
      regs_d         = regs_q;
      fifo_d         = fifo_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_reg_d   = commit_reg_q;
      commit_data_d  = commit_data_q;
      retired_d      = retired_q;

      if (push) begin
         fifo_d[wr_ptr_q] = entry_t'(wb_bundle);
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d       = rd_ptr_q + 1'b1;
         retired_d      = retired_q + 16'd1;
         commit_reg_d   = head.rd;
         commit_data_d  = head.data;
         commit_valid_d = head.is_write && (head.rd != 3'd0);
         if (commit_valid_d) begin
            regs_d[head.rd] = head.data;
         end
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Walk oldest to youngest so the youngest matching write wins.
   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      rd_data_b = regs_q[rd_addr_b];
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && fifo_q[rd_ptr_q + PTR_W'(i)].is_write) begin
            if (fifo_q[rd_ptr_q + PTR_W'(i)].rd == rd_addr_a) begin
               rd_data_a = fifo_q[rd_ptr_q + PTR_W'(i)].data;
            end
            if (fifo_q[rd_ptr_q + PTR_W'(i)].rd == rd_addr_b) begin
               rd_data_b = fifo_q[rd_ptr_q + PTR_W'(i)].data;
            end
         end
      end
      if (rd_addr_a == 3'd0) begin
         rd_data_a = 16'h0000;
      end
      if (rd_addr_b == 3'd0) begin
         rd_data_b = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 8; r++) begin
            regs_q[r] <= 16'h0000;
         end
         for (int e = 0; e < DEPTH; e++) begin
            fifo_q[e] <= '0;
         end
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_reg_q   <= 3'd0;
         commit_data_q  <= 16'h0000;
         retired_q      <= 16'h0000;
      end else begin
         regs_q         <= regs_d;
         fifo_q         <= fifo_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_reg_q   <= commit_reg_d;
         commit_data_q  <= commit_data_d;
         retired_q      <= retired_d;
      end
   end

endmodule
